// File: rtl/result_stream_reader.sv
// Drains multi-word dot-product results from mem3 and
// presents each reassembled value on a valid/ready stream.
module result_stream_reader #(
  parameter int DATA_WIDTH       = 8,
  parameter int VECTOR_WIDTH     = 4,
  parameter int RESULT_WIDTH     = 2*DATA_WIDTH+$clog2(VECTOR_WIDTH),
  parameter int MEM3_ADDR_WIDTH  = 4,
  parameter int WORDS_PER_RESULT = (RESULT_WIDTH+DATA_WIDTH-1)/DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MEM3_ADDR_WIDTH-1:0] base_addr,
  input  logic [MEM3_ADDR_WIDTH-1:0] num_results,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [MEM3_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic [RESULT_WIDTH-1:0]    res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MEM3_ADDR_WIDTH-1:0] results_sent
);

  localparam int AW    = MEM3_ADDR_WIDTH;
  localparam int IDX_W =
    (WORDS_PER_RESULT > 1) ? $clog2(WORDS_PER_RESULT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(WORDS_PER_RESULT-1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, PRESENT, DONE
  } state_t;

  state_t              state, state_n;
  logic [AW-1:0]       ptr, ptr_n;
  logic [AW-1:0]       num_q, num_n;
  logic [AW-1:0]       rd_addr_n, sent_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [RESULT_WIDTH-1:0] res_data_n;

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    num_n      = num_q;
    idx_n      = idx;
    rd_addr_n  = rd_addr;
    sent_n     = results_sent;
    res_data_n = res_data;
    unique case (1'b1)
      state == IDLE: begin
        if (start) begin
          if (num_results != '0) begin
            state_n = ISSUE;
            ptr_n   = base_addr;
            num_n   = num_results;
            sent_n  = '0;
            idx_n   = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      state == ISSUE: begin
        ptr_n   = ptr + 1'b1;
        state_n = CAPTURE;
      end
      state == CAPTURE: begin
        // Slice beyond RESULT_WIDTH in the last word is dropped
        for (int b = 0; b < RESULT_WIDTH; b++) begin
          if (b / DATA_WIDTH == int'(idx))
            res_data_n[b] = rd_data[b % DATA_WIDTH];
        end
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = PRESENT;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = ISSUE;
        end
      end
      state == PRESENT: begin
        if (res_ready) begin
          sent_n  = results_sent + 1'b1;
          state_n = (sent_n == num_q) ? DONE : ISSUE;
        end
      end
      state == DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == ISSUE)
      rd_addr_n = (state == IDLE) ? base_addr : ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      num_q        <= '0;
      idx          <= '0;
      rd_addr      <= '0;
      results_sent <= '0;
      res_data     <= '0;
      rd_en        <= 1'b0;
      res_valid    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      num_q        <= num_n;
      idx          <= idx_n;
      rd_addr      <= rd_addr_n;
      results_sent <= sent_n;
      res_data     <= res_data_n;
      rd_en        <= (state_n == ISSUE);
      res_valid    <= (state_n == PRESENT);
      done         <= (state_n == DONE);
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_result_stream_reader.sv
// Scoreboard bench for result_stream_reader with a
// synchronous-read mem3 model.
module tb_result_stream_reader;

  localparam int DW = 8;
  localparam int RW = 18;
  localparam int AW = 4;
  localparam int WPR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_results = '0;
  logic          busy, done, rd_en, res_valid;
  logic [AW-1:0] rd_addr, results_sent;
  logic [DW-1:0] rd_data = '0;
  logic [RW-1:0] res_data;
  logic          res_ready = 1'b1;

  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int aq[$];
  logic [RW-1:0] rq[$];

  result_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .num_results(num_results),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .results_sent(results_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (aq.size() == 0) check("rd_unexp", 1, 0);
        else check("rd_addr", 32'(rd_addr), 32'(aq.pop_front()));
      end
      if (res_valid && res_ready) begin
        if (rq.size() == 0) check("res_unexp", 1, 0);
        else check("res_data", 32'(res_data), 32'(rq.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [RW-1:0] exp_res(int base, int r);
    logic [DW*WPR-1:0] w;
    for (int k = 0; k < WPR; k++)
      w[k*DW +: DW] = mem[(base + WPR*r + k) % 16];
    return w[RW-1:0];
  endfunction

  task automatic pulse_start(input int base, input int n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    num_results = AW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int base, input int n);
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < WPR; k++)
        aq.push_back((base + WPR*r + k) % 16);
      rq.push_back(exp_res(base, r));
    end
    pulse_start(base, n);
  endtask

  task automatic wait_done();
    logic ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    check("done_seen", 32'(ok), 1);
  endtask

  task automatic finish_drain(input int n, input int d0);
    wait_done();
    check("sent", 32'(results_sent), 32'(n));
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("busy_end", 32'(busy), 0);
    check("done_cnt", 32'(done_cnt - d0), 1);
    check("aq_empty", 32'(aq.size()), 0);
    check("rq_empty", 32'(rq.size()), 0);
  endtask

  initial begin
    int d0;
    logic ok;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[2] = 8'h34; mem[3] = 8'h12; mem[4] = 8'h03;
    mem[5] = 8'hFF; mem[6] = 8'hFF; mem[7] = 8'hFF;
    mem[14] = 8'h01; mem[15] = 8'h02; mem[0] = 8'h01;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_data", 32'(res_data), 0);
    rst_n = 1'b1;

    // basic two-result drain
    d0 = done_cnt;
    drain(2, 2);
    finish_drain(2, d0);
    check("res_keep", 32'(res_data), 32'h3FFFF);

    // backpressure on the first result
    res_ready = 1'b0;
    d0 = done_cnt;
    drain(2, 2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = res_valid;
    end
    check("valid_seen", 32'(ok), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(res_valid), 1);
      check("bp_data", 32'(res_data), 32'h31234);
      check("bp_no_rd", 32'(rd_en), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    finish_drain(2, d0);

    // address wrap
    d0 = done_cnt;
    drain(14, 1);
    finish_drain(1, d0);
    check("wrap_data", 32'(res_data), 32'h10201);

    // zero-length drain
    d0 = done_cnt;
    pulse_start(3, 0);
    @(negedge clk);
    check("z_busy", 32'(busy), 1);
    check("z_done", 32'(done), 1);
    check("z_rd", 32'(rd_en), 0);
    @(negedge clk);
    check("z_busy2", 32'(busy), 0);
    check("z_done2", 32'(done), 0);
    check("z_cnt", 32'(done_cnt - d0), 1);

    // start while busy is ignored
    d0 = done_cnt;
    drain(2, 2);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 4'd9;
    num_results = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_drain(2, d0);

    // reset during capture
    d0 = done_cnt;
    drain(2, 2);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rd_en;
    end
    check("rd_seen", 32'(ok), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_done", 32'(done), 0);
    check("ar_rd_en", 32'(rd_en), 0);
    check("ar_addr", 32'(rd_addr), 0);
    check("ar_valid", 32'(res_valid), 0);
    check("ar_data", 32'(res_data), 0);
    check("ar_sent", 32'(results_sent), 0);
    aq.delete();
    rq.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ar_no_done", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    drain(2, 2);
    finish_drain(2, d0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
